// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: frame FSM states,
// parity-type encodings and the default data width.
package uart_rx_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 8;
    localparam logic PAR_EVEN           = 1'b0;
    localparam logic PAR_ODD            = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational expected-parity generator, shared by the RX and TX paths.
// Even type yields the XOR of the data; odd type yields its inverse.
module uart_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Frames voted RX bits (start, LSB-first data, optional parity, stop) into a word
// with registered valid/error pulses. Optional error counter: UART_RX_ERR_COUNT_EN.
module uart_rx_frame_assembler
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_data,
    input  logic                  sampled_data_valid,
`ifdef UART_RX_ERR_COUNT_EN
    input  logic                  err_count_clr,
    output logic [7:0]            err_count,
`endif
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  start_glitch,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic                  start_glitch_q, start_glitch_d;
    logic                  busy_q, busy_d;
    logic                  exp_par_s;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data    (shift_q),
        .par_typ (par_typ_q),
        .par_bit (exp_par_s)
    );

    // Next-state and pulse generation; state advances only on sampler strobes.
    always_comb begin
        state_d        = state_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_bad_d      = par_bad_q;
        p_data_d       = p_data_q;
        busy_d         = busy_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        start_glitch_d = 1'b0;
        if (sampled_data_valid) begin
            case (state_q)
                IDLE: begin
                    if (!sampled_data) begin
                        par_en_d  = par_en;
                        par_typ_d = par_typ;
                        bit_idx_d = '0;
                        busy_d    = 1'b1;
                        state_d   = DATA;
                    end else begin
                        start_glitch_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_idx_q] = sampled_data;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                PARITY: begin
                    if (sampled_data != exp_par_s) begin
                        parity_error_d = 1'b1;
                        par_bad_d      = 1'b1;
                    end else begin
                        par_bad_d = par_bad_q;
                    end
                    state_d = STOP;
                end
                STOP: begin
                    if (!sampled_data) begin
                        stop_error_d = 1'b1;
                    end else if (!par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        p_data_d = p_data_q;
                    end
                    par_bad_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) begin
            state_q        <= IDLE;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= PAR_EVEN;
            par_bad_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            start_glitch_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_bad_q      <= par_bad_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            start_glitch_q <= start_glitch_d;
            busy_q         <= busy_d;
        end
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign start_glitch = start_glitch_q;
    assign busy         = busy_q;

`ifdef UART_RX_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating error counter; counting on the _d pulses keeps it aligned with the flags.
    always_comb begin
        err_count_d = err_count_q;
        if (err_count_clr) begin
            err_count_d = 8'd0;
        end else if ((parity_error_d || stop_error_d || start_glitch_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: doc/uart_rx_frame_assembler.md
Name: uart_rx_frame_assembler

Overview:
Downstream stage of the RX data sampler. Consumes the majority-voted `sampled_data` / `sampled_data_valid` strobes one bit at a time and frames them as start, DATA_WIDTH data bits (LSB first), optional parity, and stop. Produces a parallel byte with a one-cycle valid pulse, plus parity, stop and start-glitch error flags. Runs on the same prescaled clock as the sampler and feeds the RX output register/FIFO.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9 supported).

Ports:
- clk_based_on_prescale  in   1           single clock, same as sampler
- asy_reset              in   1           reset; synchronous, active-high
- par_en                 in   1           1 = frame carries a parity bit
- par_typ                in   1           0 = even parity, 1 = odd parity
- sampled_data           in   1           voted bit from sampler
- sampled_data_valid     in   1           one-cycle strobe; sampled_data is meaningful only when high
- p_data                 out  DATA_WIDTH  last good received word
- data_valid             out  1           one-cycle pulse, p_data updated
- parity_error           out  1           one-cycle pulse
- stop_error             out  1           one-cycle pulse
- start_glitch           out  1           one-cycle pulse
- busy                   out  1           high from accepted start bit until stop bit consumed

Behaviour:
- Reset: asserted synchronously at the clock edge while asy_reset=1.
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Shift register and bit index go to 0.
  - Reset mid-frame discards the partial frame with no flags.
- All outputs are registered. Each pulse asserts in the cycle after the strobe that causes it and lasts exactly one cycle.
- The FSM acts only on cycles where sampled_data_valid=1. Every other cycle holds state.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - Strobe with bit=0: accept as start bit. Latch par_en/par_typ into internal copies, set bit_idx=0, busy=1, go to DATA.
  - Strobe with bit=1: pulse start_glitch, stay in IDLE.
- DATA:
  - Shift the bit into position bit_idx (LSB first) and increment bit_idx.
  - On the strobe where bit_idx = DATA_WIDTH-1: go to PARITY if the latched par_en=1, else go to STOP.
  - bit_idx is $clog2(DATA_WIDTH) bits wide and never wraps past DATA_WIDTH-1.
- PARITY:
  - expected = XOR of the data bits, XOR the latched par_typ.
  - If the received bit differs from expected, pulse parity_error and set an internal par_bad flag.
  - Go to STOP.
- STOP:
  - Received bit = 0: pulse stop_error.
  - Received bit = 1 and par_bad=0: load p_data and pulse data_valid.
  - In both cases clear par_bad, set busy=0 and go to IDLE.
  - When data_valid does not pulse, p_data holds its previous value.
- Config changes on par_en/par_typ mid-frame are ignored. The latched copies apply to the whole frame.
- Back-to-back frames: a start strobe on the very next strobe after the stop strobe is accepted normally. No idle gap is required.
- A frame with both a parity error and a stop error pulses both flags, in their respective cycles.

Optional Feature:
- Macro: UART_RX_ERR_COUNT_EN.
- When defined:
  - Adds output err_count[7:0].
  - Increments by 1 on every parity_error, stop_error or start_glitch pulse; each pulse counts once.
  - Saturates at 255.
  - Reset value is 0.
  - Adds input err_count_clr, a synchronous clear. Clear has priority over increment in the same cycle.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package uart_rx_pkg holds:
  - FSM state enum (IDLE/DATA/PARITY/STOP).
  - PAR_EVEN=0 and PAR_ODD=1 constants.
  - Default DATA_WIDTH constant.
- One sub-module, uart_parity_calc: purely combinational; inputs data[DATA_WIDTH-1:0] and par_typ; output is the expected parity bit. It is reused by the TX side.

Test Plan:
- par_en=0; strobes 0, then A5 LSB-first (1,0,1,0,0,1,0,1), then 1 -> data_valid pulses once, p_data=0xA5, busy falls in the same cycle, no error flags.
- par_en=1, par_typ=0; byte 0xA5 with parity bit 0, then stop 1 -> data_valid with p_data=0xA5. Repeat with parity bit 1 -> parity_error pulses one cycle after the parity strobe, no data_valid, p_data stays 0xA5.
- par_en=0; byte 0x3C with stop bit 0 -> stop_error pulses, no data_valid, p_data unchanged, FSM back in IDLE.
- In IDLE, strobe with bit=1 -> start_glitch pulses, busy stays 0. A following valid 0x55 frame is received correctly.
- Reset asserted after 4 data bits of a frame -> the next cycle all outputs are 0. A subsequent full 0x81 frame yields p_data=0x81.
- With UART_RX_ERR_COUNT_EN: 300 start glitches -> err_count=255. err_count_clr together with a glitch -> err_count=0.
